// File: rtl/dds_am_pkg.sv
// Shared types and default sizing for the DDS amplitude-modulation generator.
package dds_am_pkg;

   localparam int DW_DEF = 8;
   localparam int PW_DEF = 24;
   localparam int LW_DEF = 8;

   typedef enum logic [1:0] {
      MODE_CW   = 2'd0,
      MODE_AM   = 2'd1,
      MODE_DSB  = 2'd2,
      MODE_MUTE = 2'd3
   } mode_t;

endpackage

// File: rtl/dds_sine_lut.sv
// Sine ROM with registered read. DDS_AM_QUARTER_LUT_EN selects a quarter-wave table
// rebuilt by symmetry; the output stream and the one-cycle latency do not change.
module dds_sine_lut #(
   parameter int DW = 8,
   parameter int LW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [LW-1:0]        addr,
   output logic signed [DW-1:0] data
);

   localparam real PI = 3.14159265358979323846;

   // Round half away from zero so the table is exactly odd-symmetric.
   function automatic logic signed [DW-1:0] sine_val(input int i);
      real x;
      int  r;
      x = (2.0 ** (DW - 1) - 1.0) * $sin(2.0 * PI * real'(i) / (2.0 ** LW));
      if (x >= 0.0) r = $rtoi(x + 0.5);
      else          r = -$rtoi(0.5 - x);
      return r[DW-1:0];
   endfunction

`ifdef DDS_AM_QUARTER_LUT_EN
   localparam int QN = 2 ** (LW - 2);

   logic signed [DW-1:0] rom [0:QN];
   logic [LW-2:0]        qidx;
   logic                 neg;

   for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
      assign rom[gi] = sine_val(gi);
   end

   // Odd quadrants read the table backwards; the lower half-wave is negated.
   always_comb begin
      qidx = {1'b0, addr[LW-3:0]};
      if (addr[LW-2]) qidx = (LW-1)'(QN) - {1'b0, addr[LW-3:0]};
      neg = addr[LW-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) data <= '0;
      else     data <= neg ? -rom[qidx] : rom[qidx];
   end
`else
   logic signed [DW-1:0] rom [0:2**LW-1];

   for (genvar gi = 0; gi < 2 ** LW; gi++) begin : g_rom
      assign rom[gi] = sine_val(gi);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) data <= '0;
      else     data <= rom[addr];
   end
`endif

endmodule

// File: rtl/dds_am_gen.sv
// Two-tone DDS with CW / AM / DSB-SC / mute output and a fixed 3-cycle pipeline.
// Sine table size is selected by DDS_AM_QUARTER_LUT_EN (see dds_sine_lut).
module dds_am_gen
   import dds_am_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int PW = PW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 phase_clr,
   input  logic                 cfg_load,
   input  logic [PW-1:0]        fcw_c,
   input  logic [PW-1:0]        fcw_s,
   input  logic [DW-1:0]        depth,
   input  logic [1:0]           mode,
   output logic signed [DW-1:0] sin_c,
   output logic signed [DW-1:0] sin_s,
   output logic signed [DW-1:0] am_out,
   output logic                 out_valid
);

   localparam int XW  = 2 * DW + 3;
   localparam int DPW = 2 * DW + 1;
   localparam logic signed [DW+1:0] ENV_BIAS = (DW+2)'(2 ** (DW - 1));

   logic [PW-1:0]        fcw_c_reg, fcw_s_reg, acc_c_reg, acc_s_reg;
   logic [DW-1:0]        depth_reg, depth0_reg;
   mode_t                mode_reg, mode0_reg, mode1_reg;
   logic [LW-1:0]        addr_c, addr_s;
   logic signed [DW-1:0] lut_c, lut_s;
   logic                 v0_reg, v1_reg, v2_reg;
   logic signed [DW-1:0] sc1_reg, ss1_reg, sc2_reg, ss2_reg, am2_reg;
   logic signed [DW+1:0] env1_reg, env_next;
   logic signed [DPW-1:0] dprod;
   logic signed [XW-1:0] prod, scaled;
   logic signed [DW-1:0] am_next;

   function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
      if (&v[XW-1:DW-1] || ~|v[XW-1:DW-1]) return v[DW-1:0];
      else if (v[XW-1])                     return {1'b1, {(DW-1){1'b0}}};
      else                                  return {1'b0, {(DW-1){1'b1}}};
   endfunction

   // The sample launched on a clear edge reads phase 0, not the stale phase.
   assign addr_c = phase_clr ? '0 : acc_c_reg[PW-1 -: LW];
   assign addr_s = phase_clr ? '0 : acc_s_reg[PW-1 -: LW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_c_reg <= '0;
         acc_s_reg <= '0;
         fcw_c_reg <= '0;
         fcw_s_reg <= '0;
         depth_reg <= '0;
         mode_reg  <= MODE_CW;
      end else begin
         if (phase_clr) begin
            acc_c_reg <= '0;
            acc_s_reg <= '0;
         end else if (en) begin
            acc_c_reg <= acc_c_reg + fcw_c_reg;
            acc_s_reg <= acc_s_reg + fcw_s_reg;
         end
         if (cfg_load) begin
            fcw_c_reg <= fcw_c;
            fcw_s_reg <= fcw_s;
            depth_reg <= depth;
            mode_reg  <= mode_t'(mode);
         end
      end
   end

   dds_sine_lut #(.DW(DW), .LW(LW)) u_lut_c (
      .clk  (clk),
      .rst  (rst),
      .addr (addr_c),
      .data (lut_c)
   );

   dds_sine_lut #(.DW(DW), .LW(LW)) u_lut_s (
      .clk  (clk),
      .rst  (rst),
      .addr (addr_s),
      .data (lut_s)
   );

   always_comb begin
      dprod    = DPW'($signed({1'b0, depth0_reg})) * DPW'(lut_s);
      env_next = ENV_BIAS + (DW+2)'(dprod >>> DW);
   end

   always_comb begin
      prod    = '0;
      scaled  = '0;
      am_next = '0;
      case (mode1_reg)
         MODE_CW: am_next = sc1_reg;
         MODE_AM: begin
            prod    = XW'(sc1_reg) * XW'(env1_reg);
            scaled  = prod >>> DW;
            am_next = sat(scaled);
         end
         MODE_DSB: begin
            prod    = XW'(sc1_reg) * XW'(ss1_reg);
            scaled  = prod >>> (DW - 1);
            am_next = sat(scaled);
         end
         MODE_MUTE: am_next = '0;
         default:   am_next = '0;
      endcase
   end

   // Mode and depth ride along with each sample so a reconfiguration never
   // touches samples already in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0_reg     <= 1'b0;
         v1_reg     <= 1'b0;
         v2_reg     <= 1'b0;
         mode0_reg  <= MODE_CW;
         mode1_reg  <= MODE_CW;
         depth0_reg <= '0;
         sc1_reg    <= '0;
         ss1_reg    <= '0;
         env1_reg   <= '0;
         sc2_reg    <= '0;
         ss2_reg    <= '0;
         am2_reg    <= '0;
         out_valid  <= 1'b0;
         sin_c      <= '0;
         sin_s      <= '0;
         am_out     <= '0;
      end else begin
         v0_reg     <= en;
         mode0_reg  <= mode_reg;
         depth0_reg <= depth_reg;
         v1_reg     <= v0_reg;
         mode1_reg  <= mode0_reg;
         sc1_reg    <= lut_c;
         ss1_reg    <= lut_s;
         env1_reg   <= env_next;
         v2_reg     <= v1_reg;
         sc2_reg    <= sc1_reg;
         ss2_reg    <= ss1_reg;
         am2_reg    <= am_next;
         out_valid  <= v2_reg;
         if (v2_reg) begin
            sin_c  <= sc2_reg;
            sin_s  <= ss2_reg;
            am_out <= am2_reg;
         end
      end
   end

endmodule

// File: tb/tb_dds_am_gen.sv
// Directed plus randomized bench for dds_am_gen against a sample-level reference model.
module tb_dds_am_gen;

   localparam int  DW = 8;
   localparam int  PW = 24;
   localparam int  LW = 8;
   localparam real PI = 3.14159265358979323846;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en = 1'b0, phase_clr = 1'b0, cfg_load = 1'b0;
   logic [PW-1:0]        fcw_c = '0, fcw_s = '0;
   logic [DW-1:0]        depth = '0;
   logic [1:0]           mode = '0;
   logic signed [DW-1:0] sin_c, sin_s, am_out;
   logic                 out_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dds_am_gen #(.DW(DW), .PW(PW), .LW(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .phase_clr (phase_clr),
      .cfg_load  (cfg_load),
      .fcw_c     (fcw_c),
      .fcw_s     (fcw_s),
      .depth     (depth),
      .mode      (mode),
      .sin_c     (sin_c),
      .sin_s     (sin_s),
      .am_out    (am_out),
      .out_valid (out_valid)
   );

   typedef struct { int due; int c; int s; int am; } smp_t;

   smp_t        pend[$];
   int unsigned m_acc_c, m_acc_s, m_fc, m_fs;
   int          m_depth, m_mode, edge_no;
   int          last_c, last_s, last_am;
   int          cap_c[$], cap_am[$];

   function automatic int sine(int unsigned phase);
      real x;
      x = 127.0 * $sin(2.0 * PI * real'(phase >> (PW - LW)) / 256.0);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   function automatic int fdiv(int a, int b);
      int q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic int clamp(int v);
      return (v > 127) ? 127 : ((v < -128) ? -128 : v);
   endfunction

   task automatic model_reset();
      pend.delete();
      m_acc_c = 0; m_acc_s = 0; m_fc = 0; m_fs = 0;
      m_depth = 0; m_mode = 0;
      last_c = 0; last_s = 0; last_am = 0;
   endtask

   task automatic model_edge();
      smp_t        sm;
      int unsigned pc, ps;
      int          env;
      edge_no++;
      if (rst) begin
         model_reset();
         return;
      end
      pc = phase_clr ? 0 : m_acc_c;
      ps = phase_clr ? 0 : m_acc_s;
      if (en) begin
         sm.c   = sine(pc);
         sm.s   = sine(ps);
         sm.due = edge_no + 3;
         env    = 128 + fdiv(m_depth * sm.s, 256);
         case (m_mode)
            0:       sm.am = sm.c;
            1:       sm.am = clamp(fdiv(sm.c * env, 256));
            2:       sm.am = clamp(fdiv(sm.c * sm.s, 128));
            default: sm.am = 0;
         endcase
         pend.push_back(sm);
      end
      if (phase_clr) begin
         m_acc_c = 0;
         m_acc_s = 0;
      end else if (en) begin
         m_acc_c = (m_acc_c + m_fc) & 32'h00FF_FFFF;
         m_acc_s = (m_acc_s + m_fs) & 32'h00FF_FFFF;
      end
      if (cfg_load) begin
         m_fc = fcw_c; m_fs = fcw_s; m_depth = depth; m_mode = mode;
      end
   endtask

   task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      if (pend.size() > 0 && pend[0].due == edge_no) begin
         chk("out_valid", out_valid, 1);
         last_c  = pend[0].c;
         last_s  = pend[0].s;
         last_am = pend[0].am;
         pend.pop_front();
         cap_c.push_back(sin_c);
         cap_am.push_back(am_out);
      end else begin
         chk("out_valid_idle", out_valid, 0);
      end
      chk("sin_c", sin_c, last_c);
      chk("sin_s", sin_s, last_s);
      chk("am_out", am_out, last_am);
   endtask

   task automatic tick(bit e, bit c, bit l, int unsigned fc, int unsigned fs, int d, int m);
      en = e; phase_clr = c; cfg_load = l;
      fcw_c = fc[PW-1:0]; fcw_s = fs[PW-1:0]; depth = d[DW-1:0]; mode = m[1:0];
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic run(int n);
      repeat (n) tick(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(int n);
      repeat (n) tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic pat_chk(string tag, bit use_am, int p0, int p1, int p2, int p3);
      int p[4];
      int q[$];
      p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
      q = use_am ? cap_am : cap_c;
      chk({tag, "_count_ok"}, (q.size() >= 8) ? 1 : 0, 1);
      for (int i = 0; i < 8; i++)
         if (i < q.size()) chk(tag, q[i], p[i % 4]);
   endtask

   task automatic async_rst();
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sin_c", sin_c, 0);
      chk("rst_sin_s", sin_s, 0);
      chk("rst_am_out", am_out, 0);
      model_reset();
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      edge_no = 0;
      model_reset();

      // reset state
      idle(2);
      rst = 1'b0;
      idle(1);

      // CW carrier quarter-rate pattern
      tick(0, 1, 1, 1 << 22, 0, 0, 0);
      cap_c.delete(); cap_am.delete();
      run(11); idle(3);
      pat_chk("cw_sin_c", 0, 0, 127, 0, -127);

      // AM with zero depth halves the carrier
      tick(0, 1, 1, 1 << 22, 'h05A5A5, 0, 1);
      cap_c.delete(); cap_am.delete();
      run(11); idle(3);
      pat_chk("am_depth0", 1, 0, 63, 0, -64);

      // DSB-SC with equal tones squares the sine
      tick(0, 1, 1, 1 << 22, 1 << 22, 0, 2);
      cap_c.delete(); cap_am.delete();
      run(11); idle(3);
      pat_chk("dsb_equal", 1, 0, 126, 0, 126);

      // en gap: pipeline drains, outputs hold, phase resumes
      tick(0, 0, 1, 'h123456, 'h0789AB, 200, 1);
      run(6); idle(5); run(6); idle(3);

      // clear together with a CW->MUTE reload while samples are in flight
      tick(0, 1, 1, 1 << 22, 0, 0, 0);
      run(5);
      tick(1, 1, 1, 1 << 22, 0, 0, 3);
      run(4); idle(3);

      // asynchronous reset mid-stream
      tick(0, 0, 1, 'h2468AC, 'h013579, 180, 1);
      run(8);
      async_rst();
      idle(2); run(6); idle(3);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (i == 200) async_rst();
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) == 0, $urandom & 32'h00FF_FFFF,
              $urandom_range(0, 1 << 20), $urandom_range(0, 255), $urandom_range(0, 3));
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
